// File: rtl/key_event_queue_if.sv
// key_event_queue_if: valid/ready event handshake between the key queue and its consumer
interface key_event_queue_if;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic       ev_ready;
    modport master (output ev_valid, output ev_code, input ev_ready);
    modport slave  (input ev_valid, input ev_code, output ev_ready);
endinterface

// File: rtl/key_event_queue.sv
// key_event_queue: debounces push-buttons and queues key-press events behind a valid/ready handshake
module key_event_queue #(
    parameter int N_KEYS  = 5,
    parameter int DEB_CNT = 200000,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_KEYS-1:0]    btn,
    key_event_queue_if.master    ev,
    output logic [N_KEYS-1:0]    btn_level,
    output logic [4:0]           count,
    output logic                 overflow
);
    localparam int CW = $clog2(DEB_CNT);
    localparam int AW = $clog2(DEPTH);

    logic [N_KEYS-1:0] sync1_q, sync2_q, level_q, level_d, pending_q, pending_d;
    logic [N_KEYS-1:0] rise, grant, clr;
    logic [CW-1:0]     cnt_q [N_KEYS];
    logic [CW-1:0]     cnt_d [N_KEYS];
    logic [2:0]        mem_q [DEPTH];
    logic [2:0]        mem_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [4:0]        count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [2:0]        push_code;
    logic              push, pop, full;

    // Per-key debounce: a level is accepted only after DEB_CNT consecutive differing samples
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CNT - 1))
                    level_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        rise = level_d & ~level_q;
    end

    // Lowest-index pending key wins; a pop in the same cycle frees room when full
    always_comb begin
        push_code = '0;
        grant     = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                push_code = 3'(i);
                grant     = '0;
                grant[i]  = 1'b1;
            end
        end
        full       = count_q == 5'(DEPTH);
        pop        = (count_q != '0) && ev.ev_ready;
        push       = (|pending_q) && (!full || pop);
        clr        = push ? grant : '0;
        pending_d  = (pending_q & ~clr) | rise;
        overflow_d = overflow_q | (|(rise & pending_q & ~clr));
    end

    // FIFO storage and pointer bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = push_code;
            wr_d        = wr_q + AW'(1);
        end
        if (pop)
            rd_d = rd_q + AW'(1);
        count_d = count_q + 5'(push) - 5'(pop);
    end

    // State registers, all cleared asynchronously so queued and pending events vanish at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            pending_q  <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            pending_q  <= pending_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign ev.ev_valid = count_q != '0;
    assign ev.ev_code  = ev.ev_valid ? mem_q[rd_q] : 3'd0;
    assign btn_level   = level_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: directed stimulus with a scoreboard of expected key events
module tb_key_event_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] btn = '0;
    logic [4:0] btn_level;
    logic [4:0] count;
    logic       overflow;
    int         checks = 0;
    int         failures = 0;
    logic [2:0] exp_q [$];

    key_event_queue_if ev ();

    key_event_queue #(.N_KEYS(5), .DEB_CNT(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .ev        (ev),
        .btn_level (btn_level),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int k, input bit expect_ev);
        btn[k] = 1'b1;
        if (expect_ev) exp_q.push_back(3'(k));
        tick(8);
    endtask

    task automatic release_all();
        btn = '0;
        tick(8);
    endtask

    // Monitor: every accepted handshake must match the oldest expected event
    always @(negedge clk) begin
        if (rst && ev.ev_valid && ev.ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got code %0d expected none", ev.ev_code);
            end else begin
                check("event_order", 32'(ev.ev_code), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        ev.ev_ready = 1'b0;
        tick(3);
        check("rst_valid", 32'(ev.ev_valid), 0);
        check("rst_code", 32'(ev.ev_code), 0);
        check("rst_level", 32'(btn_level), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 1'b1;
        tick(3);

        // 1: single clean press on key 2
        btn[2] = 1'b1;
        exp_q.push_back(3'd2);
        tick(5);
        check("t1_level_early", 32'(btn_level[2]), 0);
        tick(1);
        check("t1_level_cyc6", 32'(btn_level[2]), 1);
        check("t1_valid_cyc6", 32'(ev.ev_valid), 0);
        tick(1);
        check("t1_valid", 32'(ev.ev_valid), 1);
        check("t1_code", 32'(ev.ev_code), 2);
        check("t1_count", 32'(count), 1);
        check("t1_overflow", 32'(overflow), 0);
        ev.ev_ready = 1'b1;
        tick(1);
        ev.ev_ready = 1'b0;
        check("t1_drained", 32'(count), 0);
        release_all();
        check("t1_release_level", 32'(btn_level), 0);

        // 2: bouncing key 0 never settles long enough
        for (int i = 0; i < 20; i++) begin
            btn[0] = ~i[1];
            tick(1);
            check("t2_level", 32'(btn_level[0]), 0);
            check("t2_valid", 32'(ev.ev_valid), 0);
        end
        btn[0] = 1'b0;
        tick(8);
        check("t2_level_end", 32'(btn_level[0]), 0);
        check("t2_valid_end", 32'(ev.ev_valid), 0);

        // 3: simultaneous presses drain in index order
        ev.ev_ready = 1'b1;
        btn = 5'b11010;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd4);
        tick(7);
        check("t3_code_a", 32'(ev.ev_code), 1);
        tick(1);
        check("t3_code_b", 32'(ev.ev_code), 3);
        tick(1);
        check("t3_code_c", 32'(ev.ev_code), 4);
        tick(1);
        check("t3_count", 32'(count), 0);
        check("t3_valid", 32'(ev.ev_valid), 0);
        check("t3_overflow", 32'(overflow), 0);
        ev.ev_ready = 1'b0;
        release_all();

        // 4: fill the FIFO, fifth press stays pending
        for (int k = 0; k < 5; k++) press(k, 1'b1);
        check("t4_count", 32'(count), 4);
        check("t4_head", 32'(ev.ev_code), 0);
        check("t4_overflow", 32'(overflow), 0);
        ev.ev_ready = 1'b1;
        tick(8);
        check("t4_drain_count", 32'(count), 0);
        check("t4_scoreboard", 32'(exp_q.size()), 0);
        ev.ev_ready = 1'b0;
        release_all();

        // 5: second key-4 press while pending is dropped
        for (int k = 0; k < 5; k++) press(k, 1'b1);
        btn[4] = 1'b0;
        tick(8);
        press(4, 1'b0);
        check("t5_overflow", 32'(overflow), 1);
        check("t5_count", 32'(count), 4);
        tick(3);
        check("t5_overflow_sticky", 32'(overflow), 1);
        ev.ev_ready = 1'b1;
        tick(10);
        check("t5_drain_count", 32'(count), 0);
        check("t5_overflow_after", 32'(overflow), 1);
        check("t5_scoreboard", 32'(exp_q.size()), 0);
        ev.ev_ready = 1'b0;
        release_all();

        // 6: asynchronous reset with three events queued
        for (int k = 0; k < 3; k++) press(k, 1'b0);
        check("t6_count_pre", 32'(count), 3);
        #3;
        rst = 1'b0;
        #1;
        check("t6_valid_async", 32'(ev.ev_valid), 0);
        check("t6_count_async", 32'(count), 0);
        check("t6_overflow_async", 32'(overflow), 0);
        btn = '0;
        tick(3);
        rst = 1'b1;
        ev.ev_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check("t6_valid_idle", 32'(ev.ev_valid), 0);
        end
        check("t6_level", 32'(btn_level), 0);
        check("final_scoreboard", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Input-side counterpart to the display/LED outputs of the game top level.
- Debounces the raw push-buttons (bottom[4:0]) and turns each clean press into a key-index event.
- Buffers events in a small FIFO and hands them to gameControl over a valid/ready handshake, so no press is lost while the game logic is busy.

Parameters:
- N_KEYS, 5, number of raw button inputs, 1..8.
- DEB_CNT, 200000, consecutive stable clk cycles required to accept a new level; >=2.
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock (divided clock from clock_div).
- rst  input  1  asynchronous, active-low reset.
- btn  input  N_KEYS  raw, bouncing, asynchronous button levels; 1 = pressed.
- ev_valid  output  1  FIFO head holds an event.
- ev_code  output  3  key index of head event (0..N_KEYS-1).
- ev_ready  input  1  consumer accepts head when ev_valid & ev_ready.
- btn_level  output  N_KEYS  debounced button levels.
- count  output  5  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a press is dropped.

Behaviour:
- Reset (rst=0, asynchronous): ev_valid=0, ev_code=0, btn_level=0, count=0, overflow=0. Also clears synchronizers, debounce counters, pending flags and FIFO pointers.
- Synchronization: each btn bit passes through a 2-flop synchronizer before debounce.
- Debounce, per key:
  - Counter resets to 0 whenever the synchronized level equals btn_level.
  - Otherwise the counter increments.
  - When it reaches DEB_CNT-1 with the level still different, btn_level toggles in that cycle and the counter clears.
  - A glitch shorter than DEB_CNT cycles never changes btn_level.
  - Latency from a stable raw edge to btn_level change: DEB_CNT+2 cycles.
- Press detect: a 0->1 transition of btn_level[i] sets pending[i]. Releases produce no event.
- Arbiter, one push per cycle max:
  - If any pending bit is set and FIFO not full, push the lowest set index i and clear pending[i] in the same cycle.
  - Pushed event becomes visible on ev_valid/ev_code the cycle after the push.
- Pending full: a press on key i while pending[i] is already 1 is dropped and sets overflow. overflow is cleared only by reset.
- FIFO full (count=DEPTH): no push; pending bits are held, not lost; they drain in index order once space frees.
- Pop: ev_valid & ev_ready removes the head in that cycle. ev_ready with ev_valid=0 has no effect.
- Simultaneous push and pop, including when full: occupancy unchanged and both succeed. When full, a pop frees a slot so a push in that same cycle is allowed.
- ev_valid = (count != 0). ev_code shows the head entry and is stable while ev_valid=1 and not popped.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH or underflows.
- Reset mid-operation: all queued and pending events are discarded immediately. A button still held through reset release produces an event after debounce, because btn_level restarts at 0.

Test Plan (bench uses DEB_CNT=4, DEPTH=4):
1. Reset, then btn[2]=1 held clean, ev_ready=0:
   - btn_level[2]=1 at cycle 6 after the edge.
   - ev_valid=1 with ev_code=2 one or two cycles later.
   - count=1, overflow=0.
2. btn[0] toggles 1/0 every 2 cycles for 20 cycles, then stays 0:
   - btn_level[0] stays 0.
   - No event; ev_valid=0 throughout.
3. btn[4], btn[1] and btn[3] rise in the same cycle, ev_ready=1:
   - Events pop in order 1, 3, 4 on consecutive cycles.
   - count returns to 0; overflow=0.
4. ev_ready=0; five clean presses on keys 0,1,2,3,4 in turn:
   - count=4 holding 0,1,2,3; pending[4]=1; overflow=0.
   - Raising ev_ready drains 0,1,2,3,4 in order.
5. ev_ready=0, FIFO full, pending[4] set; press key 4 again:
   - overflow=1 and stays 1.
   - Only one key-4 event is delivered after draining.
6. Assert rst low with count=3:
   - ev_valid, count and overflow drop to 0 asynchronously, before the next clk edge.
   - After release with no presses, ev_valid stays 0.
